// File: rtl/pc_unit_if.sv
// rtl/pc_unit_if.sv - command inputs and status outputs of the program counter unit
interface pc_unit_if;
  logic       stall;
  logic       jump;
  logic [7:0] jump_addr;
  logic       branch;
  logic [7:0] offset;
  logic       call;
  logic       ret;
  logic       halt;
  logic [7:0] pc_out;
  logic [2:0] depth;
  logic       halted;
  logic       ovf;
  logic       unf;

  modport master (
    output stall, jump, jump_addr, branch, offset, call, ret, halt,
    input  pc_out, depth, halted, ovf, unf
  );

  modport slave (
    input  stall, jump, jump_addr, branch, offset, call, ret, halt,
    output pc_out, depth, halted, ovf, unf
  );
endinterface

// File: rtl/pc_unit.sv
// rtl/pc_unit.sv - 8-bit program counter with return-address stack and RUN/HALT FSM
module pc_unit #(
  parameter logic [7:0] RESET_VECTOR = 8'h00,
  parameter int         STACK_DEPTH  = 4
) (
  input  logic      clock,
  input  logic      reset,
  pc_unit_if.slave  bus
);

  typedef enum logic {RUN, HALT} state_e;

  localparam logic [2:0] MAX_DEPTH = 3'(STACK_DEPTH);

  state_e     state_q, state_d;
  logic [7:0] pc_q, pc_d;
  logic [2:0] depth_q, depth_d;
  logic       ovf_q, ovf_d;
  logic       unf_q, unf_d;
  logic       push;

  // Sized to the full 3-bit depth range so depth_q indexes it directly;
  // slots at or above STACK_DEPTH are never written.
  logic [7:0] stack_q [8];

  logic [7:0] pc_inc;
  logic [2:0] top_idx;

  assign pc_inc  = pc_q + 8'd1;
  assign top_idx = depth_q - 3'd1;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    depth_d = depth_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    push    = 1'b0;
    if (state_q == RUN && !bus.stall) begin
      if (bus.halt) begin
        state_d = HALT;
      end else if (bus.ret) begin
        if (depth_q != 3'd0) begin
          pc_d    = stack_q[top_idx];
          depth_d = top_idx;
        end else begin
          unf_d = 1'b1;
        end
      end else if (bus.call) begin
        if (depth_q < MAX_DEPTH) begin
          push    = 1'b1;
          pc_d    = bus.jump_addr;
          depth_d = depth_q + 3'd1;
        end else begin
          ovf_d = 1'b1;
        end
      end else if (bus.jump) begin
        pc_d = bus.jump_addr;
      end else if (bus.branch) begin
        // 8-bit modular add equals adding the sign-extended displacement
        pc_d = pc_q + bus.offset;
      end else begin
        pc_d = pc_inc;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= RUN;
      pc_q    <= RESET_VECTOR;
      depth_q <= 3'd0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      depth_q <= depth_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // Reset suppresses the write so an interrupted call leaves no trace.
  always_ff @(posedge clock) begin
    if (!reset && push) begin
      stack_q[depth_q] <= pc_inc;
    end
  end

  assign bus.pc_out = pc_q;
  assign bus.depth  = depth_q;
  assign bus.halted = (state_q == HALT);
  assign bus.ovf    = ovf_q;
  assign bus.unf    = unf_q;

endmodule

// File: tb/tb_pc_unit.sv
// tb/tb_pc_unit.sv - randomized and directed checks of pc_unit against a queue-based model
module tb_pc_unit;
  localparam int DEPTH = 4;

  logic clock = 1'b0;
  logic reset;
  pc_unit_if bus();

  pc_unit dut (.clock(clock), .reset(reset), .bus(bus));

  always #5 clock = ~clock;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  int m_pc;
  int m_stack[$];
  bit m_halted, m_ovf, m_unf;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input bit rs, st, hl, rt, cl, jp, br, input logic [7:0] ja, off);
    if (rs) begin
      m_pc = 0; m_stack.delete(); m_halted = 0; m_ovf = 0; m_unf = 0;
    end else if (m_halted || st) begin
    end else if (hl) begin
      m_halted = 1;
    end else if (rt) begin
      if (m_stack.size() > 0) m_pc = m_stack.pop_back();
      else m_unf = 1;
    end else if (cl) begin
      if (m_stack.size() < DEPTH) begin
        m_stack.push_back((m_pc + 1) % 256);
        m_pc = int'(ja);
      end else m_ovf = 1;
    end else if (jp) begin
      m_pc = int'(ja);
    end else if (br) begin
      m_pc = (m_pc + int'($signed(off)) + 256) % 256;
    end else begin
      m_pc = (m_pc + 1) % 256;
    end
  endtask

  task automatic tick(input bit rs, st, hl, rt, cl, jp, br, input logic [7:0] ja, off);
    reset = rs; bus.stall = st; bus.halt = hl; bus.ret = rt; bus.call = cl;
    bus.jump = jp; bus.branch = br; bus.jump_addr = ja; bus.offset = off;
    @(posedge clock);
    model_step(rs, st, hl, rt, cl, jp, br, ja, off);
    @(negedge clock);
  endtask

  task automatic idle();            tick(0,0,0,0,0,0,0,8'h00,8'h00); endtask
  task automatic do_reset();        tick(1,0,0,0,0,0,0,8'h00,8'h00); endtask
  task automatic do_jump(input logic [7:0] a);   tick(0,0,0,0,0,1,0,a,8'h00); endtask
  task automatic do_branch(input logic [7:0] o); tick(0,0,0,0,0,0,1,8'h00,o); endtask
  task automatic do_call(input logic [7:0] a);   tick(0,0,0,0,1,0,0,a,8'h00); endtask
  task automatic do_ret();          tick(0,0,0,1,0,0,0,8'h00,8'h00); endtask

  always @(negedge clock) begin
    if (chk_en) begin
      check("model_pc",     bus.pc_out,          8'(m_pc));
      check("model_depth",  {5'd0, bus.depth},   8'(m_stack.size()));
      check("model_halted", {7'd0, bus.halted},  {7'd0, m_halted});
      check("model_ovf",    {7'd0, bus.ovf},     {7'd0, m_ovf});
      check("model_unf",    {7'd0, bus.unf},     {7'd0, m_unf});
    end
  end

  initial begin
    reset = 1'b1; bus.stall = 0; bus.halt = 0; bus.ret = 0; bus.call = 0;
    bus.jump = 0; bus.branch = 0; bus.jump_addr = 8'h00; bus.offset = 8'h00;
    @(negedge clock);
    do_reset();
    chk_en = 1'b1;

    check("rst_pc", bus.pc_out, 8'h00);
    check("rst_depth", {5'd0, bus.depth}, 8'h00);
    check("rst_flags", {5'd0, bus.halted, bus.ovf, bus.unf}, 8'h00);
    for (int i = 1; i <= 3; i++) begin
      idle();
      check("idle_pc", bus.pc_out, 8'(i));
    end

    do_jump(8'hFE); check("jump_fe", bus.pc_out, 8'hFE);
    idle();         check("inc_ff", bus.pc_out, 8'hFF);
    idle();         check("wrap_00", bus.pc_out, 8'h00);

    do_jump(8'h10); do_branch(8'hF0); check("branch_back", bus.pc_out, 8'h00);
    do_jump(8'h10); do_branch(8'h7F); check("branch_fwd", bus.pc_out, 8'h8F);

    do_jump(8'h20); do_call(8'h40);
    check("call_pc", bus.pc_out, 8'h40); check("call_depth", {5'd0, bus.depth}, 8'h01);
    do_ret();
    check("ret_pc", bus.pc_out, 8'h21); check("ret_depth", {5'd0, bus.depth}, 8'h00);
    do_ret();
    check("unf_pc", bus.pc_out, 8'h21); check("unf_flag", {7'd0, bus.unf}, 8'h01);

    do_reset();
    for (int i = 0; i < 5; i++) do_call(8'h30 + 8'(i));
    check("ovf_pc", bus.pc_out, 8'h33);
    check("ovf_depth", {5'd0, bus.depth}, 8'h04);
    check("ovf_flag", {7'd0, bus.ovf}, 8'h01);
    tick(0,1,0,1,1,0,0,8'h55,8'h00);
    check("stall_pc", bus.pc_out, 8'h33);
    check("stall_depth", {5'd0, bus.depth}, 8'h04);
    do_ret();
    check("pop_pc", bus.pc_out, 8'h33);
    tick(1,0,0,0,1,0,0,8'h66,8'h00);
    check("rst_call_pc", bus.pc_out, 8'h00);
    check("rst_call_depth", {5'd0, bus.depth}, 8'h00);

    do_jump(8'h05);
    tick(0,0,1,0,0,0,0,8'h00,8'h00);
    check("halt_pc", bus.pc_out, 8'h05); check("halted", {7'd0, bus.halted}, 8'h01);
    do_jump(8'h77);
    check("halt_jump_ignored", bus.pc_out, 8'h05);
    tick(1,1,0,0,0,0,0,8'h00,8'h00);
    check("unhalt_pc", bus.pc_out, 8'h00); check("unhalted", {7'd0, bus.halted}, 8'h00);

    for (int i = 0; i < 3000; i++) begin
      tick($urandom_range(0, 63) == 0, $urandom_range(0, 7) == 0,
           $urandom_range(0, 63) == 0, $urandom_range(0, 4) == 0,
           $urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0,
           $urandom_range(0, 3) == 0, 8'($urandom), 8'($urandom));
    end

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/pc_unit.md
PC_UNIT -- requirements
Module: pc_unit

Interface
REQ-001 Parameter RESET_VECTOR, default 8'h00: PC value loaded on reset.
REQ-002 Parameter STACK_DEPTH, default 4: number of return-address entries (range 1..7).
REQ-003 clock  input  1  single clock; all state changes on rising edge.
REQ-004 reset  input  1  synchronous, active-high; sampled on the rising edge of clock.
REQ-005 stall  input  1  freeze all state for this cycle.
REQ-006 jump  input  1  load PC with jump_addr.
REQ-007 jump_addr  input  8  absolute target.
REQ-008 branch  input  1  relative branch, taken when asserted.
REQ-009 offset  input  8  two's-complement branch displacement, -128..+127.
REQ-010 call  input  1  push return address, load PC with jump_addr.
REQ-011 ret  input  1  pop return address into PC.
REQ-012 halt  input  1  enter HALT state.
REQ-013 pc_out  output  8  current instruction address to instruction memory.
REQ-014 depth  output  3  number of valid stack entries.
REQ-015 halted  output  1  high while in HALT.
REQ-016 ovf  output  1  sticky: call attempted with stack full.
REQ-017 unf  output  1  sticky: ret attempted with stack empty.

Function
REQ-018 The FSM SHALL have two states, RUN and HALT; pc_out, depth, ovf and unf SHALL all be registered outputs.
REQ-019 In RUN, per-cycle priority SHALL be: stall > halt > ret > call > jump > branch > increment.
REQ-020 stall=1: PC, stack, depth, flags and state unchanged.
REQ-021 halt=1 (RUN, no stall): next state HALT, PC unchanged.
REQ-022 ret with depth>0: PC <= top entry, depth decrements, next cycle.
REQ-023 ret with depth=0: PC unchanged, unf <= 1, depth stays 0.
REQ-024 call with depth<STACK_DEPTH: push (pc_out+1) mod 256, PC <= jump_addr, depth increments.
REQ-025 call with depth=STACK_DEPTH: no push, PC unchanged, ovf <= 1.
REQ-026 jump: PC <= jump_addr.
REQ-027 branch: PC <= (pc_out + sign-extended offset) mod 256, 8-bit wrap.
REQ-028 No control input asserted: PC <= (pc_out + 1) mod 256; 8'hFF wraps to 8'h00.
REQ-029 Latency: each command SHALL be applied at the next rising edge; pc_out SHALL reflect it one cycle after the command is sampled.
REQ-030 In HALT, all inputs except reset SHALL be ignored; PC, stack and flags SHALL hold; HALT SHALL be left only by reset.
REQ-031 ovf and unf SHALL remain set until reset.
REQ-032 Stack entries beyond depth are don't-care and SHALL never be observable on pc_out.

Reset
REQ-033 reset=1 at a rising edge SHALL override every other input, including stall and HALT.
REQ-034 On that edge: pc_out <= RESET_VECTOR, depth <= 0, ovf <= 0, unf <= 0, halted <= 0, state <= RUN.
REQ-035 Reset asserted mid-call or mid-ret SHALL discard the operation; there is no partial push or pop.

Verification
REQ-036 Reset, then 3 idle cycles -> pc_out 00, 01, 02, 03; depth 0; all flags 0.
REQ-037 Jump to 8'hFE, then 2 idle cycles -> pc_out FE, FF, 00 (wrap-around).
REQ-038 At pc 10, branch with offset 8'hF0 -> pc_out 00; at pc 10, branch with offset 8'h7F -> pc_out 8F.
REQ-039 At pc 20, call 40 -> pc 40, depth 1; ret -> pc 21, depth 0; ret again -> pc 21 holds, unf=1.
REQ-040 With default depth 4: 5 consecutive calls -> depth 4, ovf=1, pc unchanged on the 5th call; call+ret+stall asserted together -> no change.
REQ-041 halt at pc 05 -> pc holds 05, halted=1, jump ignored; reset -> pc 00, halted=0.
